// File: rtl/jtpopeye_dwnld_if.sv
// Bus bundle between the MiST I/O download stream, the SDRAM frame and the PROM loaders.
// With JTPOPEYE_DWN_CHECKSUM_EN defined the bundle also carries the running byte checksum.
interface jtpopeye_dwnld_if #(
  parameter int PROM_SLOTS = 4
);
  logic                  downloading;
  logic [21:0]           ioctl_addr;
  logic [7:0]            ioctl_data;
  logic                  ioctl_wr;
  logic                  sdram_ack;
  logic [21:0]           prog_addr;
  logic [7:0]            prog_data;
  logic [1:0]            prog_mask;
  logic                  prog_we;
  logic [PROM_SLOTS-1:0] prom_we;
  logic [7:0]            prom_addr;
  logic [7:0]            prom_data;
  logic                  busy;
  logic                  overflow;
  logic                  dwn_done;
`ifdef JTPOPEYE_DWN_CHECKSUM_EN
  logic [15:0]           checksum;
`endif

  // I/O controller and SDRAM frame side
  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we,
    input  prom_we, prom_addr, prom_data, busy, overflow, dwn_done
`ifdef JTPOPEYE_DWN_CHECKSUM_EN
    , input checksum
`endif
  );

  // download stage side
  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we,
    output prom_we, prom_addr, prom_data, busy, overflow, dwn_done
`ifdef JTPOPEYE_DWN_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/jtpopeye_dwnld.sv
// ROM download stage: SDRAM write requests with a one-entry skid, PROM strobes, end-of-download pulse.
// Optional JTPOPEYE_DWN_CHECKSUM_EN adds a 16-bit running sum of every routed byte.
module jtpopeye_dwnld #(
  parameter logic [21:0] PROM_START = 22'h1_A000,
  parameter int          PROM_SLOTS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  jtpopeye_dwnld_if.slave io
);
  localparam logic [22:0] PROM_END = {1'b0, PROM_START} + 23'(256 * PROM_SLOTS);

  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;

  state_t      state_q, state_d;
  logic        accept_p0, sdram_p0, prom_p0, ack_p0;
  logic [21:0] off_p0;
  logic [1:0]  mask_p0;
  logic        load_new, load_skid_out, load_skid, ovf_set;
  logic        dl_q, dl_rise, dl_fall, armed_q, fire;
  logic [21:0] skid_addr;
  logic [7:0]  skid_data;
  logic [1:0]  skid_mask;

  assign accept_p0 = io.ioctl_wr & io.downloading;
  assign off_p0    = io.ioctl_addr - PROM_START;
  assign sdram_p0  = accept_p0 && (io.ioctl_addr < PROM_START);
  assign prom_p0   = accept_p0 && !(io.ioctl_addr < PROM_START) && ({1'b0, io.ioctl_addr} < PROM_END);
  assign mask_p0   = io.ioctl_addr[0] ? 2'b01 : 2'b10;
  assign ack_p0    = io.sdram_ack & io.prog_we;
  assign dl_rise   = io.downloading & ~dl_q;
  assign dl_fall   = ~io.downloading & dl_q;

  always_comb begin
    state_d       = state_q;
    load_new      = 1'b0;
    load_skid_out = 1'b0;
    load_skid     = 1'b0;
    ovf_set       = 1'b0;
    case (state_q)
      IDLE: if (sdram_p0) begin
        state_d  = REQ;
        load_new = 1'b1;
      end
      REQ: begin
        if (ack_p0 && sdram_p0) load_new = 1'b1;
        else if (ack_p0)        state_d = IDLE;
        else if (sdram_p0) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end
      end
      FULL: begin
        if (ack_p0) begin
          load_skid_out = 1'b1;
          if (sdram_p0) load_skid = 1'b1;
          else          state_d   = REQ;
        end else if (sdram_p0) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // done fires on the cycle the queue empties, so the pulse trails the final ack by one cycle
    fire = (armed_q | dl_fall) & (state_d == IDLE) & ~dl_rise;
  end

  // Stage p0 -> p1: control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      io.prog_we  <= 1'b0;
      io.busy     <= 1'b0;
      dl_q        <= 1'b0;
      armed_q     <= 1'b0;
      io.overflow <= 1'b0;
      io.dwn_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      io.prog_we  <= state_d != IDLE;
      io.busy     <= state_d != IDLE;
      dl_q        <= io.downloading;
      io.dwn_done <= fire;
      if (dl_rise || fire) armed_q <= 1'b0;
      else if (dl_fall)    armed_q <= 1'b1;
      if (dl_rise)      io.overflow <= 1'b0;
      else if (ovf_set) io.overflow <= 1'b1;
    end
  end

  // Stage p0 -> p1: SDRAM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.prog_addr <= '0;
      io.prog_data <= '0;
      io.prog_mask <= 2'b11;
    end else if (load_new) begin
      io.prog_addr <= {1'b0, io.ioctl_addr[21:1]};
      io.prog_data <= io.ioctl_data;
      io.prog_mask <= mask_p0;
    end else if (load_skid_out) begin
      io.prog_addr <= skid_addr;
      io.prog_data <= skid_data;
      io.prog_mask <= skid_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_addr <= {1'b0, io.ioctl_addr[21:1]};
      skid_data <= io.ioctl_data;
      skid_mask <= mask_p0;
    end
  end

  // Stage p0 -> p1: PROM strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.prom_we   <= '0;
      io.prom_addr <= '0;
      io.prom_data <= '0;
    end else begin
      io.prom_we <= prom_p0 ? (PROM_SLOTS'(1) << off_p0[21:8]) : '0;
      if (prom_p0) begin
        io.prom_addr <= off_p0[7:0];
        io.prom_data <= io.ioctl_data;
      end
    end
  end

`ifdef JTPOPEYE_DWN_CHECKSUM_EN
  logic frozen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.checksum <= '0;
      frozen_q    <= 1'b0;
    end else begin
      if (dl_rise)   frozen_q <= 1'b0;
      else if (fire) frozen_q <= 1'b1;
      if (dl_rise)
        io.checksum <= (sdram_p0 || prom_p0) ? {8'd0, io.ioctl_data} : 16'd0;
      else if (!frozen_q && (sdram_p0 || prom_p0))
        io.checksum <= io.checksum + {8'd0, io.ioctl_data};
    end
  end
`else
  // checksum feature not built
`endif
endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Directed bench for jtpopeye_dwnld with a scoreboard queue of expected SDRAM writes.
module tb_jtpopeye_dwnld;
  localparam logic [21:0] PROM_START = 22'h1_A000;
  localparam int          PROM_SLOTS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtpopeye_dwnld_if #(.PROM_SLOTS(PROM_SLOTS)) bus();

  jtpopeye_dwnld #(.PROM_START(PROM_START), .PROM_SLOTS(PROM_SLOTS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_prog_addr"}, bus.prog_addr, 0);
    chk({tag, "_prog_data"}, bus.prog_data, 0);
    chk({tag, "_prog_mask"}, bus.prog_mask, 2'b11);
    chk({tag, "_prog_we"},   bus.prog_we, 0);
    chk({tag, "_prom_we"},   bus.prom_we, 0);
    chk({tag, "_prom_addr"}, bus.prom_addr, 0);
    chk({tag, "_prom_data"}, bus.prom_data, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_overflow"},  bus.overflow, 0);
    chk({tag, "_dwn_done"},  bus.dwn_done, 0);
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_prog_we"},  bus.prog_we, 32'(exp_q.size() != 0));
    chk({tag, "_busy"},     bus.busy, 32'(exp_q.size() != 0));
    chk({tag, "_overflow"}, bus.overflow, 32'(exp_ovf));
    if (exp_q.size() != 0) begin
      chk({tag, "_prog_addr"}, bus.prog_addr, exp_q[0].addr);
      chk({tag, "_prog_data"}, bus.prog_data, exp_q[0].data);
      chk({tag, "_prog_mask"}, bus.prog_mask, exp_q[0].mask);
    end
  endtask

  // One clock of stimulus; an ack retires the scoreboard head before the new byte is queued
  task automatic step(input bit wr, input logic [21:0] a, input logic [7:0] d, input bit ack);
    wr_t e;
    bus.ioctl_wr   = wr;
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.sdram_ack  = ack;
    if (ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL ack_pending: observed empty scoreboard expected a queued write");
      end else begin
        e = exp_q.pop_front();
        chk("ack_prog_we",   bus.prog_we, 1);
        chk("ack_prog_addr", bus.prog_addr, e.addr);
        chk("ack_prog_data", bus.prog_data, e.data);
        chk("ack_prog_mask", bus.prog_mask, e.mask);
      end
    end
    if (wr && bus.downloading && (a < PROM_START)) begin
      if (exp_q.size() < 2) exp_q.push_back('{addr: a >> 1, data: d, mask: a[0] ? 2'b01 : 2'b10});
      else exp_ovf = 1'b1;
    end
    tick();
    bus.ioctl_wr  = 1'b0;
    bus.sdram_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;
    bus.sdram_ack   = 1'b0;
    repeat (3) tick();
    rst_chk("reset");

    rst_n = 1'b1;
    tick();
    bus.downloading = 1'b1;
    tick();

    // single write held without ack
    step(1, 22'h0003, 8'h5A, 0);
    chk("single_addr", bus.prog_addr, 22'h0001);
    chk("single_mask", bus.prog_mask, 2'b01);
    check_q("single");
    repeat (5) begin
      tick();
      check_q("hold");
    end
    step(0, '0, '0, 1);
    check_q("single_acked");

    // back-to-back, third byte overflows
    step(1, 22'h10, 8'hAA, 0);
    step(1, 22'h11, 8'hBB, 0);
    step(1, 22'h12, 8'hCC, 0);
    check_q("b2b_full");
    step(0, '0, '0, 1);
    check_q("b2b_one");
    step(0, '0, '0, 1);
    check_q("b2b_drained");

    // ack coincident with a new byte in REQ and FULL
    step(1, 22'h20, 8'h11, 0);
    step(1, 22'h21, 8'h22, 1);
    check_q("req_ack_byte");
    step(1, 22'h30, 8'h33, 0);
    step(1, 22'h31, 8'h44, 1);
    check_q("full_ack_byte");
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    check_q("mixed_drained");

    // PROM routing
    step(1, PROM_START + 22'h1FF, 8'hC3, 0);
    chk("prom_we",        bus.prom_we, 4'b0010);
    chk("prom_addr",      bus.prom_addr, 8'hFF);
    chk("prom_data",      bus.prom_data, 8'hC3);
    chk("prom_no_prog",   bus.prog_we, 0);
    tick();
    chk("prom_we_single", bus.prom_we, 0);
    step(1, PROM_START + 22'h400, 8'h77, 0);
    chk("beyond_prom_we", bus.prom_we, 0);
    chk("beyond_prog_we", bus.prog_we, 0);
    chk("beyond_data",    bus.prom_data, 8'hC3);
    step(1, PROM_START + 22'h005, 8'h9E, 0);
    chk("slot0_we",       bus.prom_we, 4'b0001);
    chk("slot0_addr",     bus.prom_addr, 8'h05);

    // end of download with one request pending
    step(1, 22'h40, 8'h55, 0);
    bus.downloading = 1'b0;
    repeat (4) begin
      tick();
      chk("pending_no_done", bus.dwn_done, 0);
    end
    step(1, 22'h50, 8'h66, 0);
    check_q("ignored_wr");
    step(0, '0, '0, 1);
    chk("done_pulse",   bus.dwn_done, 1);
    chk("done_prog_we", bus.prog_we, 0);
    repeat (3) begin
      tick();
      chk("done_once", bus.dwn_done, 0);
    end

    // new download clears overflow; checksum run
    bus.downloading = 1'b1;
    exp_ovf = 1'b0;
    tick();
    check_q("restart");
    step(1, 22'h0000, 8'hFF, 0);
    step(1, PROM_START + 22'h002, 8'h02, 0);
    step(1, 22'h0001, 8'h10, 0);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    check_q("cks_drained");
    bus.downloading = 1'b0;
    tick();
    chk("idle_done", bus.dwn_done, 1);
`ifdef JTPOPEYE_DWN_CHECKSUM_EN
    chk("checksum", bus.checksum, 16'h0111);
`endif
    tick();
    chk("idle_done_end", bus.dwn_done, 0);

    // reset while FULL
    bus.downloading = 1'b1;
    tick();
    step(1, 22'h60, 8'hA1, 0);
    step(1, 22'h61, 8'hA2, 0);
    check_q("pre_reset_full");
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk("async_reset");
    exp_q.delete();
    exp_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("post_reset_done", bus.dwn_done, 0);
      chk("post_reset_we",   bus.prog_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jtpopeye_dwnld.md
# jtpopeye_dwnld

ROM download stage between the MiST I/O controller and the SDRAM and PROM loaders.
- Consumes the byte stream `ioctl_addr/ioctl_data/ioctl_wr`.
- Produces the `prog_addr/prog_data/prog_mask/prog_we` SDRAM write requests used by the frame, with an `sdram_ack` handshake and a one-entry skid buffer.
- Diverts the colour/timing PROM region to one-cycle BRAM write strobes.
- Signals end of download once every queued write has been accepted.

## Interface
Parameters
- `PROM_START`, 22'h1_A000, first byte address of the PROM region; lower addresses go to SDRAM.
- `PROM_SLOTS`, 4, number of 256-byte PROM slots following `PROM_START`. Bytes beyond the last slot are discarded.

Ports
- `clk`  in  1  system clock (40 MHz)
- `rst_n`  in  1  asynchronous active-low reset
- `downloading`  in  1  high while a ROM transfer is in progress
- `ioctl_addr`  in  22  byte address of the incoming byte
- `ioctl_data`  in  8  incoming byte
- `ioctl_wr`  in  1  one-cycle strobe, byte valid
- `sdram_ack`  in  1  one-cycle pulse, current `prog_*` request accepted
- `prog_addr`  out  22  SDRAM word address (byte address >> 1)
- `prog_data`  out  8  byte to write; the frame duplicates it on both lanes
- `prog_mask`  out  2  active-low lane enable: even byte 2'b10, odd byte 2'b01
- `prog_we`  out  1  SDRAM write request, held until acknowledged
- `prom_we`  out  `PROM_SLOTS`  one-hot, one-cycle PROM write strobe
- `prom_addr`  out  8  PROM byte address
- `prom_data`  out  8  PROM byte
- `busy`  out  1  request outstanding or skid buffer occupied
- `overflow`  out  1  sticky, a byte was lost because both output and skid were full
- `dwn_done`  out  1  one-cycle pulse at end of download

## Operation
- **Accept**: a byte is accepted only when `ioctl_wr` and `downloading` are both 1. `ioctl_wr` with `downloading` low is ignored.
- **Address decode** on the accepted byte:
  - `ioctl_addr < PROM_START`: SDRAM path.
  - `PROM_START <= a < PROM_START + 256*PROM_SLOTS`: PROM path. Slot is `(a-PROM_START)>>8`; `prom_addr` is `(a-PROM_START)[7:0]`.
  - Any other address: the byte is dropped.
- **SDRAM path**: one output register plus one skid entry. Three states: IDLE (output empty), REQ (output valid, skid empty) and FULL (both valid).
  - IDLE + byte → REQ.
  - REQ + ack → IDLE.
  - REQ + byte → FULL.
  - REQ + ack + byte → REQ, new byte in the output register.
  - FULL + ack → REQ, skid moves to output.
  - FULL + ack + byte → FULL, skid moves to output and the new byte goes to the skid.
  - FULL + byte without ack: byte dropped, `overflow` set.
  - Order of SDRAM writes always equals arrival order.
- **PROM path**: no handshake and independent of the SDRAM queue. `prom_we` bit pulses for exactly one cycle.
- **End of download**:
  - A falling edge of `downloading` arms a done flag.
  - `dwn_done` pulses once when the flag is armed and the state is IDLE, then the flag clears.
  - A rising edge of `downloading` clears the armed flag and `overflow`.
- **Reset**: asserting `rst_n` low mid-transfer discards the queued bytes.
- `busy` = state != IDLE.

## Timing
- All outputs are registered. Reset values: `prog_addr`=0, `prog_data`=0, `prog_mask`=2'b11, `prog_we`=0, `prom_we`=0, `prom_addr`=0, `prom_data`=0, `busy`=0, `overflow`=0, `dwn_done`=0; state is IDLE.
- SDRAM latency: `prog_we` and the `prog_*` fields are valid on the cycle after the `ioctl_wr` sample edge.
- `prog_*` fields are stable while `prog_we`=1.
- `sdram_ack` is sampled only when `prog_we`=1. `prog_we` falls on the cycle after ack unless a next byte is loaded, in which case it stays 1 with new fields.
- PROM latency: `prom_we/prom_addr/prom_data` are valid one cycle after the `ioctl_wr` sample edge.
- `dwn_done` comes at the earliest 1 cycle after the falling edge of `downloading`, or 1 cycle after the final ack if later.

## Configuration
- `JTPOPEYE_DWN_CHECKSUM_EN` defined:
  - Adds output `checksum` [15:0], the modulo-2^16 sum of every accepted byte on both paths.
  - Cleared on reset and on the rising edge of `downloading`.
  - Updated one cycle after acceptance.
  - Frozen when `dwn_done` pulses.
- Undefined: no `checksum` port, no adder; all other behaviour is identical.

## Test plan
- **SDRAM single write**: byte 0x5A at 0x0003 → next cycle `prog_addr`=0x0001, `prog_mask`=2'b01, `prog_data`=0x5A, `prog_we`=1. Hold ack low 5 cycles → fields stable. Ack → `prog_we`=0 the following cycle.
- **Back-to-back**: bytes at 0x10, 0x11, 0x12 on consecutive cycles with ack withheld → third byte dropped, `overflow`=1. Acks then show 0x10 then 0x11 in order, and `busy` falls after the second ack.
- **PROM routing**: byte 0xC3 at `PROM_START`+0x1FF → `prom_we`=4'b0010 for one cycle, `prom_addr`=0xFF, `prom_data`=0xC3, no `prog_we`. Byte at `PROM_START`+0x400 → no strobes at all.
- **End of download**: `downloading` falls with one request pending → no `dwn_done` until ack, then exactly one pulse the cycle after.
- **Reset mid-transfer**: `rst_n` low with state FULL → all outputs at reset values immediately, no later `dwn_done`.
- **Checksum (macro defined)**: bytes 0xFF, 0x02, 0x10 → `checksum`=0x0111 at `dwn_done`.
